exc_ctrl: RTL
=============

// Module: exc_ctrl
// PURPOSE
//  Exception control stage downstream of the main decoder in the single-cycle LEGv8 core with exceptions.
//  - Consumes the decoder's Exc, ERet and EStatus outputs.
//  - Holds the exception registers ELR, ESR and exception count, plus the handler state.
//  - Produces the PC redirect (vector or return) and the MRS read data.
//  - Synchronises the external interrupt and feeds it back to the decoder as ExtIRQ.
// PARAMETERS
//  N           64      datapath / PC width
//  EXC_VECTOR  64'hD8  handler entry address
//  SYNC_STAGES 2       irq_in synchroniser depth (>=2)
//  CNT_W       16      exception counter width
// PORTS
//  clk          in   1     core clock, rising edge
//  reset        in   1     asynchronous, active-low reset
//  irq_in       in   1     external interrupt request, asynchronous, level
//  PC           in   N     address of the current instruction
//  Exc          in   1     decoder: exception raised this cycle
//  ERet         in   1     decoder: ERET executing this cycle
//  EStatus      in   4     decoder cause code (0001 = IRQ, 0010 = invalid opcode)
//  sys_sel      in   2     MRS source: 0 ELR, 1 ESR, 2 count (zero-extended), 3 zero
//  ExtIRQ       out  1     to decoder: take an IRQ on this instruction
//  irq_ack      out  1     one-cycle pulse when an IRQ exception is taken
//  PCexc_sel    out  1     1 = next PC comes from PCexc_target
//  PCexc_target out  N     redirect address
//  sys_rdata    out  N     MRS read data, combinational from sys_sel
//  in_handler   out  1     state == HANDLER
//  halt         out  1     state == LOCKUP; top level freezes the PC
// BEHAVIOUR
//  Reset (reset=0, async):
//   - State RUN; ELR, ESR, count, synchroniser and irq_pending cleared.
//   - All outputs 0; sys_rdata follows sys_sel over the cleared registers.
//  IRQ path:
//   - irq_in passes through SYNC_STAGES flops, then a rising-edge detect.
//   - An edge sets irq_pending.
//   - ExtIRQ = irq_pending & (state == RUN), combinational. No IRQs are taken in HANDLER or LOCKUP.
//   - irq_pending clears on the edge at which irq_ack = 1.
//   - If a new edge arrives in the same cycle as the ack, irq_pending stays set (set wins).
//   - Latency: irq_in rising to ExtIRQ = SYNC_STAGES+1 cycles.
//  State machine: RUN, HANDLER, LOCKUP.
//   - RUN & Exc: redirect to EXC_VECTOR; next state HANDLER.
//     - ESR <= EStatus.
//     - If EStatus == 0001: ELR <= PC (the preempted instruction re-executes) and irq_ack = 1.
//     - Otherwise: ELR <= PC+4 (skip the faulting instruction).
//     - count <= count+1, saturating at all-ones.
//   - RUN & ERet & ~Exc: ERET outside a handler is a no-op; PCexc_sel=0, no state change.
//   - HANDLER & ERet & ~Exc: PCexc_sel=1, PCexc_target=ELR, next state RUN.
//   - HANDLER & Exc (double fault): next state LOCKUP; ESR <= EStatus; ELR unchanged.
//   - LOCKUP: halt=1, PCexc_sel=0; exits only on reset.
//   - Exc and ERet together: Exc has priority.
//  Redirect:
//   - PCexc_sel and PCexc_target are combinational in the same cycle as Exc/ERet (single-cycle core).
//   - All register updates happen on the following rising clk edge.
//  Widths: PC+4 wraps modulo 2^N; ESR is zero-extended to N bits on sys_rdata.
//  Reset asserted mid-handler: immediate return to RUN; a pending IRQ is discarded.
// TESTING
//  1. Invalid opcode: PC=0x40, Exc=1, EStatus=0010 in RUN
//     -> PCexc_sel=1, target=0xD8; next cycle ELR=0x44, ESR=2, in_handler=1, count=1.
//  2. ERET in HANDLER with ELR=0x44 -> target=0x44, PCexc_sel=1; next cycle in_handler=0.
//     ERET in RUN -> PCexc_sel=0.
//  3. irq_in rises at cycle 0 -> ExtIRQ=1 at cycle 3.
//     Then Exc=1, EStatus=0001, PC=0x80 -> irq_ack pulse, ELR=0x80, ExtIRQ=0.
//  4. irq edge while in HANDLER -> ExtIRQ stays 0; after ERET -> ExtIRQ=1 the next cycle.
//     Edge coincident with irq_ack -> pending remains 1.
//  5. Exc=1 while in HANDLER -> halt=1, PCexc_sel=0; holds under further Exc/ERet;
//     reset=0 mid-cycle -> outputs 0 immediately.
//  6. count forced to 16'hFFFF, then one more exception -> count stays 16'hFFFF;
//     sys_sel=2 -> sys_rdata=64'hFFFF.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception control for the single-cycle LEGv8 core: ELR/ESR/count registers, RUN/HANDLER/LOCKUP state,
// PC redirect to the vector or ELR, MRS read mux and a synchronised, edge-detected external IRQ.
module exc_ctrl #(
    parameter int             N           = 64,
    parameter logic [N-1:0]   EXC_VECTOR  = N'(64'hD8),
    parameter int             SYNC_STAGES = 2,
    parameter int             CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    input  logic [N-1:0]     PC,
    input  logic             Exc,
    input  logic             ERet,
    input  logic [3:0]       EStatus,
    input  logic [1:0]       sys_sel,
    output logic             ExtIRQ,
    output logic             irq_ack,
    output logic             PCexc_sel,
    output logic [N-1:0]     PCexc_target,
    output logic [N-1:0]     sys_rdata,
    output logic             in_handler,
    output logic             halt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        LOCKUP  = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [N-1:0]           elr, elr_nx;
    logic [3:0]             esr;
    logic [CNT_W-1:0]       count;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_prev;
    logic                   irq_pending;
    logic                   irq_edge;

    logic                   pc_sel;
    logic [N-1:0]           pc_tgt;
    logic                   ack;
    logic                   ld_elr;
    logic                   ld_esr;
    logic                   cnt_inc;

    assign irq_edge = sync_q[SYNC_STAGES-1] & ~irq_prev;

    always_comb begin
        state_nx = state;
        pc_sel   = 1'b0;
        pc_tgt   = '0;
        ack      = 1'b0;
        ld_elr   = 1'b0;
        ld_esr   = 1'b0;
        cnt_inc  = 1'b0;
        elr_nx   = elr;
        case (state)
            RUN: begin
                if (Exc) begin
                    state_nx = HANDLER;
                    pc_sel   = 1'b1;
                    pc_tgt   = EXC_VECTOR;
                    ld_elr   = 1'b1;
                    ld_esr   = 1'b1;
                    cnt_inc  = 1'b1;
                    // An IRQ preempts the instruction, so it must re-execute; faults skip it.
                    if (EStatus == 4'b0001) begin
                        ack    = 1'b1;
                        elr_nx = PC;
                    end else begin
                        elr_nx = PC + N'(4);
                    end
                end
            end
            HANDLER: begin
                if (Exc) begin
                    state_nx = LOCKUP;
                    ld_esr   = 1'b1;
                end else if (ERet) begin
                    state_nx = RUN;
                    pc_sel   = 1'b1;
                    pc_tgt   = elr;
                end
            end
            LOCKUP: begin
                state_nx = LOCKUP;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            elr         <= '0;
            esr         <= '0;
            count       <= '0;
            sync_q      <= '0;
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            state    <= state_nx;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_in};
            irq_prev <= sync_q[SYNC_STAGES-1];
            // A fresh edge in the ack cycle keeps the request pending.
            irq_pending <= (irq_pending & ~ack) | irq_edge;
            if (ld_elr) elr <= elr_nx;
            if (ld_esr) esr <= EStatus;
            if (cnt_inc && !(&count)) count <= count + CNT_W'(1);
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign PCexc_sel    = pc_sel & reset;
    assign PCexc_target = reset ? pc_tgt : '0;
    assign irq_ack      = ack & reset;
    assign ExtIRQ       = irq_pending & (state == RUN) & reset;
    assign in_handler   = (state == HANDLER);
    assign halt         = (state == LOCKUP);

    always_comb begin
        sys_rdata = '0;
        case (sys_sel)
            2'd0:    sys_rdata = elr;
            2'd1:    sys_rdata = N'(esr);
            2'd2:    sys_rdata = N'(count);
            default: sys_rdata = '0;
        endcase
    end

endmodule
